// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling at OVERSAMPLE x bit rate.
// Define UART_RX_MAJORITY_EN to sample each bit as a 3-cycle majority vote of the line.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 uart_clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_status,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StWaitHigh, StIdle, StStart, StData, StStop} state_e;

    state_e                state_q, state_d;
    logic [1:0]            sync_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  status_q, status_d;
    logic                  ferr_q, ferr_d;
    logic                  rxd_s;
    logic                  sample_v;

    assign rxd_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    assign sample_v = (rxd_s & hist_q[0]) | (rxd_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample_v = rxd_s;
`endif

    // State register plus datapath flops
    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            state_q  <= StWaitHigh;
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            status_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[0], rxd};
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            status_q <= status_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        status_d = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            StWaitHigh: begin
                if (rxd_s) state_d = StIdle;
            end
            StIdle: begin
                if (!rxd_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = sample_v ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    shift_d = {sample_v, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IdxLast) state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed
                if (cnt_q == CntFull) begin
                    cnt_d = '0;
                    if (sample_v) begin
                        data_d   = shift_q;
                        status_d = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StWaitHigh;
        endcase
    end

    always_comb begin
        rx_busy      = (state_q != StIdle);
        rx_data      = data_q;
        rx_status    = status_q;
        rx_frame_err = ferr_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued with expected byte, kind and due cycle,
// and checked when rx_status or rx_frame_err pulses.
module tb_uart_rx;

    logic       uart_clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .uart_clk    (uart_clk),
        .reset       (reset),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_status   (rx_status),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 uart_clk = ~uart_clk;

    int unsigned cyc = 0;
    always @(posedge uart_clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [7:0]  data;
        int unsigned due;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every pulse must match the oldest queued expectation exactly
    always @(negedge uart_clk) begin
        exp_t e;
        if (rx_status || rx_frame_err) begin
            check_eq("pulse_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("kind_err", 32'(rx_frame_err), 32'(e.err));
                check_eq("kind_ok", 32'(rx_status), 32'(!e.err));
                check_eq("rx_data", 32'(rx_data), 32'(e.data));
                check_eq("latency", cyc, e.due);
            end
        end
    end

    task automatic line(input logic val, input int n);
        repeat (n) begin
            @(posedge uart_clk);
            #1;
            rxd = val;
        end
    endtask

    // abort: pulse reset from data bit 4 to late in data bit 6 (line low at release)
    task automatic drive_frame(input logic [7:0] data, input logic stop_val,
                               input logic glitch, input logic abort);
        logic [9:0] bits;
        logic [7:0] got;
        exp_t       e;
        bits = {stop_val, data, 1'b0};
`ifdef UART_RX_MAJORITY_EN
        got = data;
`else
        got = glitch ? ~data : data;
`endif
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 16; c++) begin
                @(posedge uart_clk);
                #1;
                rxd = bits[b] ^ (glitch && b >= 1 && b <= 8 && c == 8);
                if (b == 0 && c == 0 && !abort) begin
                    e.err  = !stop_val;
                    e.data = stop_val ? got : last_good;
                    e.due  = cyc + 155;
                    sb_q.push_back(e);
                    if (stop_val) last_good = got;
                end
                if (abort && b == 5 && c == 4) reset = 1'b1;
                if (abort && b == 7 && c == 12) reset = 1'b0;
            end
        end
    endtask

    initial begin
        rxd   = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge uart_clk);
        #1;
        check_eq("rst_busy", 32'(rx_busy), 32'd1);
        check_eq("rst_data", 32'(rx_data), 32'd0);
        check_eq("rst_status", 32'(rx_status), 32'd0);
        check_eq("rst_ferr", 32'(rx_frame_err), 32'd0);
        reset = 1'b0;
        line(1'b1, 10);
        check_eq("busy_idle0", 32'(rx_busy), 32'd0);

        drive_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        line(1'b1, 20);

        // Back-to-back: next start bit right after a 16-cycle stop bit
        drive_frame(8'h00, 1'b1, 1'b0, 1'b0);
        drive_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        line(1'b1, 20);

        // Short low glitch is rejected at the start-bit check
        line(1'b0, 4);
        line(1'b1, 1);
        check_eq("busy_glitch", 32'(rx_busy), 32'd1);
        line(1'b1, 30);
        check_eq("busy_after_glitch", 32'(rx_busy), 32'd0);

        drive_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        line(1'b0, 40);
        check_eq("busy_break", 32'(rx_busy), 32'd1);
        line(1'b1, 16);
        drive_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        line(1'b1, 20);

        drive_frame(8'h81, 1'b1, 1'b0, 1'b1);
        last_good = 8'h00;
        line(1'b1, 20);
        check_eq("rst_clear", 32'(rx_data), 32'd0);
        drive_frame(8'h81, 1'b1, 1'b0, 1'b0);
        line(1'b1, 20);

        drive_frame(8'h55, 1'b1, 1'b1, 1'b0);
        line(1'b1, 40);
        check_eq("final_data", 32'(rx_data), 32'(last_good));
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
